// File: rtl/tick_counter_pkg.sv
// Shared state encoding and debounce sizing for the tick-driven LED counter.
package tick_counter_pkg;

  localparam logic [1:0] ST_PAUSED   = 2'd0;
  localparam logic [1:0] ST_RUN_UP   = 2'd1;
  localparam logic [1:0] ST_RUN_DOWN = 2'd2;

  localparam int DEB_CW = 4;

  typedef enum logic [1:0] {
    PAUSED   = ST_PAUSED,
    RUN_UP   = ST_RUN_UP,
    RUN_DOWN = ST_RUN_DOWN
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: synchronizer, tick-paced debounce, and a one-cycle press pulse
// on each accepted 0->1 transition of the debounced level.
module btn_debounce
  import tick_counter_pkg::*;
#(
  parameter int DEB_TICKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam logic [DEB_CW-1:0] LAST_CNT = DEB_CW'(DEB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_CW-1:0]      cnt_q;
  logic                   level_q;
  logic                   level_prev;
  logic                   sync_lvl;

  assign sync_lvl  = sync_q[SYNC_STAGES-1];
  assign btn_level = level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      level_prev <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      level_prev <= level_q;
      btn_press  <= level_q & ~level_prev;
      // The counter only advances while the synchronized level disagrees;
      // any agreement restarts the hold window, which is what rejects glitches.
      if (sync_lvl == level_q) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == LAST_CNT) begin
          level_q <= sync_lvl;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + DEB_CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tick_counter_ctrl.sv
// Run/pause/direction controller driving a wrapping up/down LED count,
// stepped by the slow tick enable and commanded by three debounced buttons.
module tick_counter_ctrl
  import tick_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEB_TICKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_pause,
  output logic [WIDTH-1:0] count_out,
  output logic             running,
  output logic             dir_up
);

  state_t     state;
  logic [2:0] btn_lvl;
  logic       unused_lvl;
  logic       up_ev;
  logic       down_ev;
  logic       pause_ev;
  logic       up_only;
  logic       down_only;
  logic       pause_only;

  btn_debounce #(.DEB_TICKS(DEB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_deb_up (
    .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_up),
    .btn_level(btn_lvl[0]), .btn_press(up_ev)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_deb_down (
    .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_down),
    .btn_level(btn_lvl[1]), .btn_press(down_ev)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS), .SYNC_STAGES(SYNC_STAGES)) u_deb_pause (
    .clk(clk), .reset(reset), .tick(tick), .btn_raw(btn_pause),
    .btn_level(btn_lvl[2]), .btn_press(pause_ev)
  );

  // Debounced levels are kept only as probe points; the FSM acts on press pulses.
  assign unused_lvl = ^btn_lvl;

  // Conflicting up+down cancels the whole cycle, pause included.
  assign up_only    = up_ev & ~down_ev;
  assign down_only  = down_ev & ~up_ev;
  assign pause_only = pause_ev & ~up_ev & ~down_ev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PAUSED;
      count_out <= '0;
      running   <= 1'b0;
      dir_up    <= 1'b1;
    end else begin
      // The step uses the pre-edge state, so a same-cycle command waits a tick.
      if (tick) begin
        if (state == RUN_UP) begin
          count_out <= count_out + WIDTH'(1);
        end else if (state == RUN_DOWN) begin
          count_out <= count_out - WIDTH'(1);
        end
      end

      case (state)
        PAUSED, RUN_UP, RUN_DOWN: begin
          if (up_only) begin
            state   <= RUN_UP;
            running <= 1'b1;
            dir_up  <= 1'b1;
          end else if (down_only) begin
            state   <= RUN_DOWN;
            running <= 1'b1;
            dir_up  <= 1'b0;
          end else if (pause_only) begin
            if (state == PAUSED) begin
              state   <= dir_up ? RUN_UP : RUN_DOWN;
              running <= 1'b1;
            end else begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
        end
        default: begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Randomized bench for tick_counter_ctrl against a behavioural model of the
// button/debounce/run-pause rules, plus literal checks at the interesting points.
module tb_tick_counter_ctrl;

  localparam int WIDTH       = 4;
  localparam int DEB_TICKS   = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MOD         = 1 << WIDTH;
  localparam int W           = WIDTH + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tick = 1'b0;
  logic             btn_up = 1'b0;
  logic             btn_down = 1'b0;
  logic             btn_pause = 1'b0;
  logic [WIDTH-1:0] count_out;
  logic             running;
  logic             dir_up;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  tick_counter_ctrl #(.WIDTH(WIDTH), .DEB_TICKS(DEB_TICKS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_pause(btn_pause),
    .count_out(count_out), .running(running), .dir_up(dir_up)
  );

  // ---------------- clock / tick ----------------
  always #5 clk = ~clk;

  initial begin
    int gap;
    gap = 0;
    forever begin
      @(negedge clk);
      if (gap == 0) begin
        tick = 1'b1;
        gap  = $urandom_range(2, 5);
      end else begin
        tick = 1'b0;
        gap--;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_step is the signed amount added on each tick: +1 up, -1 down, 0 paused.
  int m_count;
  int m_step;
  bit m_dir;
  bit sh[3][SYNC_STAGES];
  bit lvl[3];
  int held[3];
  bit pend1[3];
  bit pend2[3];

  task automatic model_reset();
    m_count = 0;
    m_step  = 0;
    m_dir   = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < SYNC_STAGES; k++) sh[b][k] = 1'b0;
      lvl[b]   = 1'b0;
      held[b]  = 0;
      pend1[b] = 1'b0;
      pend2[b] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit raw[3];
    bit ev[3];
    bit s;
    bit rise;
    raw[0] = btn_up;
    raw[1] = btn_down;
    raw[2] = btn_pause;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 3; b++) ev[b] = pend2[b];
    if (tick) m_count = (m_count + m_step + MOD) % MOD;
    if (ev[0] && ev[1]) begin
      // conflicting commands: nothing happens
    end else if (ev[0]) begin
      m_step = 1;
      m_dir  = 1'b1;
    end else if (ev[1]) begin
      m_step = -1;
      m_dir  = 1'b0;
    end else if (ev[2]) begin
      m_step = (m_step != 0) ? 0 : (m_dir ? 1 : -1);
    end
    for (int b = 0; b < 3; b++) begin
      rise = 1'b0;
      s    = sh[b][SYNC_STAGES-1];
      if (s == lvl[b]) begin
        held[b] = 0;
      end else if (tick) begin
        held[b]++;
        if (held[b] == DEB_TICKS) begin
          lvl[b]  = s;
          held[b] = 0;
          rise    = s;
        end
      end
      pend2[b] = pend1[b];
      pend1[b] = rise;
      for (int k = SYNC_STAGES - 1; k > 0; k--) sh[b][k] = sh[b][k-1];
      sh[b][0] = raw[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_edge();
      exp_q.push_back({WIDTH'(m_count), (m_step != 0), m_dir});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_count", int'(count_out), int'(e[W-1:2]));
        check("model_running", int'(running), int'(e[1]));
        check("model_dir_up", int'(dir_up), int'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  // Hold the masked buttons for n ticks plus the synchronizer depth, so the
  // synchronized level sees at least n ticks, then release and settle.
  task automatic press(input logic [2:0] mask, input int hold, input int rel);
    @(negedge clk);
    btn_up    = mask[0];
    btn_down  = mask[1];
    btn_pause = mask[2];
    wait_ticks(hold);
    repeat (SYNC_STAGES) @(posedge clk);
    @(negedge clk);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_pause = 1'b0;
    wait_ticks(rel);
    @(negedge clk);
  endtask

  task automatic wait_count(input int v, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (int'(count_out) == v) found = 1'b1;
    end
    check(name, int'(found), 1);
  endtask

  task automatic expect_outs(input string name, input int run_e, input int dir_e);
    check({name, "_running"}, int'(running), run_e);
    check({name, "_dir_up"}, int'(dir_up), dir_e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hold_v;
    logic [2:0] mask;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", int'(count_out), 0);
    expect_outs("reset", 0, 1);
    reset = 1'b1;

    wait_ticks(20);
    @(negedge clk);
    check("idle_count", int'(count_out), 0);
    expect_outs("idle", 0, 1);

    press(3'b001, 6, 6);
    expect_outs("run_up", 1, 1);
    wait_count(15, "reach_15");
    wait_ticks(1);
    @(negedge clk);
    check("wrap_up_to_0", int'(count_out), 0);

    press(3'b010, 6, 6);
    expect_outs("run_down", 1, 0);
    press(3'b100, 6, 6);
    expect_outs("paused", 0, 0);
    hold_v = m_count;
    wait_ticks(10);
    @(negedge clk);
    check("pause_hold", int'(count_out), hold_v);
    press(3'b100, 6, 2);
    expect_outs("resume_down", 1, 0);
    wait_count(0, "reach_0");
    wait_ticks(1);
    @(negedge clk);
    check("wrap_down_to_15", int'(count_out), 15);

    press(3'b001, 6, 6);
    expect_outs("up_before_glitch", 1, 1);
    press(3'b010, 2, 6);
    expect_outs("glitch_rejected", 1, 1);
    press(3'b010, 4, 6);
    expect_outs("down_after_4", 1, 0);

    press(3'b011, 6, 6);
    expect_outs("up_down_ignored", 1, 0);
    press(3'b100, 6, 6);
    expect_outs("pause_again", 0, 0);
    press(3'b101, 6, 6);
    expect_outs("up_beats_pause", 1, 1);

    wait_count(9, "reach_9");
    btn_up = 1'b1;
    reset  = 1'b0;
    #1;
    check("midreset_count", int'(count_out), 0);
    expect_outs("midreset", 0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(2);
    @(negedge clk);
    expect_outs("redebounce_early", 0, 1);
    wait_ticks(6);
    @(negedge clk);
    expect_outs("redebounce_done", 1, 1);
    btn_up = 1'b0;
    wait_ticks(6);

    repeat (40) begin
      mask = 3'($urandom_range(0, 7));
      press(mask, $urandom_range(1, 7), $urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_counter_ctrl.md
Name: tick_counter_ctrl

Overview:
- Downstream consumer of the slow-tick clock divider's one-cycle `clk_slow` pulse.
- Debounces three push-buttons (up, down, pause) against that tick.
- Runs a small run/pause/direction state machine and drives a wrapping up/down count onto the board LEDs.
- Everything is in the single `clk` domain; the tick is used as an enable, never as a clock.

Parameters:
- WIDTH, 4: count width in bits (LED count).
- DEB_TICKS, 4: consecutive ticks a synchronized button must hold a new level before it is accepted; legal range 1..15.
- SYNC_STAGES, 2: flip-flop stages in each button synchronizer; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  active-low, asynchronous reset; deassertion is synchronous to `clk` at board level.
- tick  in  1  one-`clk`-cycle enable pulse from the clock divider.
- btn_up  in  1  raw asynchronous button, high = pressed.
- btn_down  in  1  raw asynchronous button, high = pressed.
- btn_pause  in  1  raw asynchronous button, high = pressed.
- count_out  out  WIDTH  current count, drives LEDs.
- running  out  1  high in RUN_UP or RUN_DOWN.
- dir_up  out  1  high when the current or remembered direction is up.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - count_out=0, state=PAUSED, dir_up=1, running=0.
  - All synchronizer flops, debounce counters and debounced levels are cleared to 0.
  - Reset asserted mid-operation aborts everything immediately, with no partial step.
- **Synchronizer:** each button passes through SYNC_STAGES flops. Synchronized level s lags the raw level by SYNC_STAGES cycles.
- **Debounce, per button, with debounced level d and counter c:**
  - If s==d, c is cleared.
  - If s!=d and tick=1, c increments.
  - When c reaches DEB_TICKS-1 on a tick with s!=d, d takes s and c clears.
  - A glitch shorter than DEB_TICKS ticks never changes d.
  - Counter width is 4 bits.
- **Press event:** a one-cycle pulse on a 0->1 transition of d, registered one cycle after d changes. Release generates no event.
- **States:** PAUSED, RUN_UP, RUN_DOWN. Transitions on press events:
  - up event: any state -> RUN_UP; dir_up<=1.
  - down event: any state -> RUN_DOWN; dir_up<=0.
  - pause event from RUN_UP or RUN_DOWN: -> PAUSED; dir_up is held.
  - pause event from PAUSED: -> RUN_UP if dir_up=1, else RUN_DOWN.
- **Simultaneous events:**
  - up and down in the same cycle: both ignored, and any pause event in that cycle is also ignored.
  - up or down together with pause: up or down wins, pause is ignored.
- **Count step:**
  - On tick=1 in RUN_UP: count <= count+1, modulo 2^WIDTH, so all-ones wraps to 0.
  - On tick=1 in RUN_DOWN: count <= count-1, modulo 2^WIDTH, so 0 wraps to all-ones.
  - In PAUSED, count holds.
- **Same-cycle tick and state change:** the step uses the state registered before the edge. The new state takes effect from the next tick.
- **Output timing:**
  - running and dir_up are registered, decoded from the state register.
  - count_out is the count register directly.
  - Latency from a raw button edge to the state change is SYNC_STAGES cycles, plus DEB_TICKS ticks, plus 2 cycles.
- **Illegal state encoding:** recovers to PAUSED on the next clock.

Decomposition:
- **Package `tick_counter_pkg`:**
  - State encoding constants ST_PAUSED=2'd0, ST_RUN_UP=2'd1, ST_RUN_DOWN=2'd2.
  - Debounce counter width constant DEB_CW=4.
- **Sub-module `btn_debounce`:**
  - Contents: synchronizer, debounce counter, debounced level and press-pulse generator.
  - Ports: clk, reset, tick, btn_raw, btn_level, btn_press.
  - Instantiated three times.
- **Top level:** FSM and counter only.

Test Plan:
- **Reset and idle:** reset=0 for 3 cycles, then release, then 20 ticks with no buttons -> count_out=0, running=0, dir_up=1 throughout.
- **Run up and wrap:** press btn_up and hold for 6 ticks (DEB_TICKS=4) -> running=1, dir_up=1. Count increments once per tick, and from count 15 the next tick gives 0.
- **Pause and resume:** in RUN_DOWN at count 3, press pause -> count holds 3 for 10 ticks. Press pause again -> RUN_DOWN resumes, next tick gives 2, and from 0 the next tick gives 15.
- **Glitch rejection:** btn_down high for 2 ticks then low -> no event, state and count unchanged. High for 4 ticks -> exactly one down event.
- **Simultaneous buttons:** btn_up and btn_down debounced in the same cycle -> state unchanged. Up and pause together from PAUSED -> RUN_UP.
- **Reset mid-run:** assert reset while RUN_UP at count 9, with btn_up still held -> immediate count_out=0 and PAUSED. After release, up re-triggers only after a fresh DEB_TICKS-tick debounce.
